// File: rtl/usr_btn_ctrl_pkg.sv
// Shared types and elaboration helpers for the user-button gesture controller.
package usr_btn_pkg;

    // Controller states; the encoding is visible on state_mon for debug/LEDs.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS1  = 3'd1,
        ST_GAP     = 3'd2,
        ST_PRESS2  = 3'd3,
        ST_SYSRST  = 3'd4,
        ST_BOOT    = 3'd5,
        ST_LOCKOUT = 3'd6
    } btn_state_e;

    // Milliseconds to clock cycles, rounded up. 64-bit math so 48 MHz * 1000 ms fits.
    function automatic int ms_to_clks(input longint freq, input longint ms);
        longint num;
        num = freq * ms;
        return int'((num + 64'sd999) / 64'sd1000);
    endfunction

    // Width of a saturating timer able to hold the larger of two cycle counts.
    function automatic int timer_width(input int a, input int b);
        int m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/usr_btn_ctrl_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for the raw button pin.
// The debounced level follows the synchronised level only after it has
// differed for DB_CLKS consecutive cycles; any bounce restarts the count.
module btn_debounce #(
    parameter int DB_CLKS            = 1,
    parameter int BUTTON_LOGIC_LEVEL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic usr_btn,
    output logic btn_db
);

    localparam int            CW       = $clog2(DB_CLKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CLKS - 1);
    localparam logic          PRESSED  = 1'(BUTTON_LOGIC_LEVEL);

    logic          sync1_q;
    logic          sync2_q;
    logic          btn_s;
    logic          db_q;
    logic [CW-1:0] cnt_q;

    // Synchronise the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= usr_btn;
            sync2_q <= sync1_q;
        end
    end

    // Map the board polarity onto an active-high "pressed" level.
    always_comb begin
        if (PRESSED) begin
            btn_s = sync2_q;
        end else begin
            btn_s = ~sync2_q;
        end
    end

    // Count consecutive cycles of disagreement; flip the debounced level when stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (btn_s != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_q  <= btn_s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/usr_btn_ctrl.sv
// User-button gesture controller: single click -> 1-cycle click pulse,
// double click -> timed sys_rst pulse, long press -> latched boot_rst.
module usr_btn_ctrl
    import usr_btn_pkg::*;
#(
    parameter int CLK_FREQUENCY          = 48000000,
    parameter int BUTTON_LOGIC_LEVEL     = 1,
    parameter int DEBOUNCE_MS            = 10,
    parameter int DOUBLE_CLICK_MS        = 300,
    parameter int LONG_PRESS_MS          = 1000,
    parameter int SYS_RST_PULSE_CYCLES   = 16,
    parameter int SYS_RESET_LOGIC_LEVEL  = 1,
    parameter int BOOT_RESET_LOGIC_LEVEL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usr_btn,
    output logic       sys_rst,
    output logic       boot_rst,
    output logic       click,
    output logic       busy,
    output logic [2:0] state_mon
);

    localparam int DB_CLKS   = ms_to_clks(longint'(CLK_FREQUENCY), longint'(DEBOUNCE_MS));
    localparam int DC_CLKS   = ms_to_clks(longint'(CLK_FREQUENCY), longint'(DOUBLE_CLICK_MS));
    localparam int LONG_CLKS = ms_to_clks(longint'(CLK_FREQUENCY), longint'(LONG_PRESS_MS));
    localparam int TW        = timer_width(LONG_CLKS, DC_CLKS);
    localparam int PW        = $clog2(SYS_RST_PULSE_CYCLES + 1);

    localparam logic [TW-1:0] LONG_T     = TW'(LONG_CLKS);
    localparam logic [TW-1:0] DC_T       = TW'(DC_CLKS);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
    localparam logic [PW-1:0] PULSE_LAST = PW'(SYS_RST_PULSE_CYCLES - 1);
    localparam logic          SYS_ON     = 1'(SYS_RESET_LOGIC_LEVEL);
    localparam logic          BOOT_ON    = 1'(BOOT_RESET_LOGIC_LEVEL);

    // Refuse to build with degenerate timing constants.
    if (DB_CLKS < 1 || DC_CLKS < 1 || LONG_CLKS < 1 || SYS_RST_PULSE_CYCLES < 1) begin : g_param_check
        $error("usr_btn_ctrl: every cycle constant and SYS_RST_PULSE_CYCLES must be at least 1");
    end

    btn_state_e    state_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [PW-1:0] pulse_q;
    logic          sys_act_q;
    logic          boot_act_q;
    logic          click_q;
    logic          btn_db;

    btn_debounce #(
        .DB_CLKS            (DB_CLKS),
        .BUTTON_LOGIC_LEVEL (BUTTON_LOGIC_LEVEL)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .usr_btn (usr_btn),
        .btn_db  (btn_db)
    );

    // Saturating increment of the gesture timer; it must never wrap back to a short count.
    always_comb begin
        timer_d = timer_q;
        if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Gesture FSM with registered action outputs; timeouts take priority over same-cycle edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            pulse_q    <= '0;
            sys_act_q  <= 1'b0;
            boot_act_q <= 1'b0;
            click_q    <= 1'b0;
        end else begin
            click_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (btn_db) begin
                        state_q <= ST_PRESS1;
                        timer_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRESS1: begin
                    timer_q <= timer_d;
                    if (timer_d == LONG_T) begin
                        state_q    <= ST_BOOT;
                        boot_act_q <= 1'b1;
                    end else if (!btn_db) begin
                        state_q <= ST_GAP;
                        timer_q <= '0;
                    end else begin
                        state_q <= ST_PRESS1;
                    end
                end
                ST_GAP: begin
                    timer_q <= timer_d;
                    if (timer_d == DC_T) begin
                        // Second press never came in time: report a single click.
                        click_q <= 1'b1;
                        if (btn_db) begin
                            state_q <= ST_PRESS1;
                            timer_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (btn_db) begin
                        state_q <= ST_PRESS2;
                        timer_q <= '0;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_PRESS2: begin
                    timer_q <= timer_d;
                    if (timer_d == LONG_T) begin
                        state_q    <= ST_BOOT;
                        boot_act_q <= 1'b1;
                    end else if (!btn_db) begin
                        state_q   <= ST_SYSRST;
                        pulse_q   <= '0;
                        sys_act_q <= 1'b1;
                    end else begin
                        state_q <= ST_PRESS2;
                    end
                end
                ST_SYSRST: begin
                    if (pulse_q == PULSE_LAST) begin
                        sys_act_q <= 1'b0;
                        state_q   <= ST_LOCKOUT;
                    end else begin
                        pulse_q <= pulse_q + PW'(1);
                    end
                end
                ST_BOOT: begin
                    // Latched until reset; the button is ignored here.
                    boot_act_q <= 1'b1;
                    state_q    <= ST_BOOT;
                end
                ST_LOCKOUT: begin
                    if (!btn_db) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_LOCKOUT;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    timer_q    <= '0;
                    sys_act_q  <= 1'b0;
                    boot_act_q <= 1'b0;
                end
            endcase
        end
    end

    assign sys_rst   = SYS_ON  ? sys_act_q  : ~sys_act_q;
    assign boot_rst  = BOOT_ON ? boot_act_q : ~boot_act_q;
    assign click     = click_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_mon = state_q;

endmodule

// File: tb/tb_usr_btn_ctrl.sv
// Directed bench for usr_btn_ctrl at 1 kHz (1 ms = 1 cycle): DB=4, DC=20, LONG=50, pulse=8.
// Pin change set after edge k reaches btn_db at edge k+6; the FSM reacts at edge k+7.
module tb_usr_btn_ctrl;

    localparam int S_IDLE   = 0;
    localparam int S_PRESS1 = 1;
    localparam int S_BOOT   = 5;

    logic       clk;
    logic       rst;
    logic       usr_btn;
    logic       sys_rst;
    logic       boot_rst;
    logic       click;
    logic       busy;
    logic [2:0] state_mon;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int click_n, click_cyc, sys_n, sys_first, boot_first;
    int excl = 0;

    typedef struct {
        int p1;
        int g;
        int p2;
        int e_click;
        int e_sys;
        int e_boot;
        int e_state;
    } row_t;

    row_t rows[9];

    usr_btn_ctrl #(
        .CLK_FREQUENCY        (1000),
        .BUTTON_LOGIC_LEVEL   (1),
        .DEBOUNCE_MS          (4),
        .DOUBLE_CLICK_MS      (20),
        .LONG_PRESS_MS        (50),
        .SYS_RST_PULSE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .usr_btn   (usr_btn),
        .sys_rst   (sys_rst),
        .boot_rst  (boot_rst),
        .click     (click),
        .busy      (busy),
        .state_mon (state_mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs mid-cycle: count pulses, remember when they happened, flag overlaps.
    always @(negedge clk) begin
        if (click === 1'b1) begin
            click_n++;
            click_cyc = cyc;
        end
        if (sys_rst === 1'b1) begin
            if (sys_n == 0) sys_first = cyc;
            sys_n++;
        end
        if (boot_rst === 1'b1 && boot_first < 0) boot_first = cyc;
        if ((int'(click) + int'(sys_rst) + int'(boot_rst)) > 1) excl++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_mon();
        click_n    = 0;
        click_cyc  = -1;
        sys_n      = 0;
        sys_first  = -1;
        boot_first = -1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        usr_btn = 1'b0;
        step(1);
        rst = 1'b0;
        clr_mon();
    endtask

    // Press p1, optionally gap g then press p2, release, settle, then compare totals.
    task automatic run_row(input int idx, input row_t r);
        do_reset();
        usr_btn = 1'b1;
        step(r.p1);
        usr_btn = 1'b0;
        if (r.p2 > 0) begin
            step(r.g);
            usr_btn = 1'b1;
            step(r.p2);
            usr_btn = 1'b0;
        end
        step(90);
        chk($sformatf("row%0d_clicks", idx), click_n, r.e_click);
        chk($sformatf("row%0d_sysrst_cycles", idx), sys_n, r.e_sys);
        chk($sformatf("row%0d_boot", idx), int'(boot_rst), r.e_boot);
        chk($sformatf("row%0d_state", idx), int'(state_mon), r.e_state);
    endtask

    initial begin
        int r0;
        int r2;
        int p0;
        bit db_seen;
        bit left_idle;

        rows[0] = '{10, 0,  0, 1, 0, 0, S_IDLE};   // single click
        rows[1] = '{10, 8, 10, 0, 8, 0, S_IDLE};   // double click
        rows[2] = '{60, 0,  0, 0, 0, 1, S_BOOT};   // long press
        rows[3] = '{10, 19, 10, 0, 8, 0, S_IDLE};  // gap one short of timeout: still double
        rows[4] = '{10, 20, 10, 2, 0, 0, S_IDLE};  // gap at timeout: two single clicks
        rows[5] = '{10, 8, 55, 0, 0, 1, S_BOOT};   // second press held long
        rows[6] = '{3,  0,  0, 0, 0, 0, S_IDLE};   // shorter than debounce
        rows[7] = '{49, 0,  0, 1, 0, 0, S_IDLE};   // just under long press
        rows[8] = '{50, 0,  0, 0, 0, 1, S_BOOT};   // long press wins over same-cycle release

        rst     = 1'b1;
        usr_btn = 1'b0;
        clr_mon();
        step(3);
        chk("reset_sys_rst", int'(sys_rst), 0);
        chk("reset_boot_rst", int'(boot_rst), 0);
        chk("reset_click", int'(click), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_state", int'(state_mon), S_IDLE);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_row(i, rows[i]);
        end

        // Bounce rejection: pin toggles every 2 cycles for 30 cycles.
        do_reset();
        db_seen   = 1'b0;
        left_idle = 1'b0;
        for (int i = 0; i < 30; i++) begin
            usr_btn = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
            if (dut.u_debounce.btn_db === 1'b1) db_seen = 1'b1;
            if (state_mon !== 3'd0) left_idle = 1'b1;
        end
        usr_btn = 1'b0;
        step(10);
        chk("bounce_db_rose", int'(db_seen), 0);
        chk("bounce_left_idle", int'(left_idle), 0);
        chk("bounce_outputs", click_n + sys_n + (boot_first >= 0 ? 1 : 0), 0);

        // Single click exact timing: click 27 cycles after the pin release.
        do_reset();
        usr_btn = 1'b1;
        step(10);
        r0 = cyc;
        usr_btn = 1'b0;
        step(40);
        chk("single_click_cycle", click_cyc, r0 + 27);
        chk("single_click_count", click_n, 1);
        chk("single_no_sysrst", sys_n, 0);
        chk("single_busy_idle", int'(busy), 0);

        // Double click exact timing: 8-cycle sys_rst from 7 cycles after second release.
        do_reset();
        usr_btn = 1'b1; step(10);
        usr_btn = 1'b0; step(8);
        usr_btn = 1'b1; step(10);
        r2 = cyc;
        usr_btn = 1'b0;
        step(30);
        chk("double_sys_first", sys_first, r2 + 7);
        chk("double_sys_len", sys_n, 8);
        chk("double_no_click", click_n, 0);

        // Long press: boot_rst at press+57, held after release, cleared by rst.
        do_reset();
        p0 = cyc;
        usr_btn = 1'b1; step(60);
        usr_btn = 1'b0; step(20);
        chk("long_boot_first", boot_first, p0 + 57);
        chk("long_boot_held", int'(boot_rst), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("long_boot_cleared", int'(boot_rst), 0);
        chk("long_state_idle", int'(state_mon), S_IDLE);

        // Gap of exactly 20: click and straight to PRESS1 on the same edge.
        do_reset();
        usr_btn = 1'b1; step(10);
        r0 = cyc;
        usr_btn = 1'b0; step(20);
        usr_btn = 1'b1; step(7);
        chk("gap20_click", int'(click), 1);
        chk("gap20_state", int'(state_mon), S_PRESS1);
        step(1);
        chk("gap20_click_one_cycle", int'(click), 0);
        usr_btn = 1'b0;
        step(60);
        chk("gap20_no_sysrst", sys_n, 0);

        // Reset in the 3rd cycle of the sys_rst pulse, then a full pulse again.
        do_reset();
        usr_btn = 1'b1; step(10);
        usr_btn = 1'b0; step(8);
        usr_btn = 1'b1; step(10);
        usr_btn = 1'b0; step(9);
        chk("midrst_pulse_active", int'(sys_rst), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_sys_cleared", int'(sys_rst), 0);
        chk("midrst_state_idle", int'(state_mon), S_IDLE);
        clr_mon();
        usr_btn = 1'b1; step(10);
        usr_btn = 1'b0; step(8);
        usr_btn = 1'b1; step(10);
        usr_btn = 1'b0; step(30);
        chk("midrst_full_pulse", sys_n, 8);

        chk("outputs_exclusive", excl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
